// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional checksum stage is enabled by defining IMEM_LOAD_CSUM_EN.
package imem_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Image checksum is a plain modulo-2^32 sum of words
  function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                 input logic [WORD_W-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer: collects three bytes and presents the
// completed word combinationally on the handshake of the fourth byte.
module imem_byte_packer
  import imem_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int BCW = $clog2(BYTES_PER_WORD);

  logic [BCW-1:0]    b_r;
  logic [WORD_W-9:0] low_r;

  // Last byte completes the word in the same cycle it is accepted
  always_comb begin
    word_valid = byte_en && (b_r == BCW'(BYTES_PER_WORD - 1));
    word       = {byte_data, low_r};
  end

  // Byte position counter and storage for the lower three bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r   <= BCW'(0);
      low_r <= {(WORD_W-8){1'b0}};
    end else if (clear) begin
      b_r <= BCW'(0);
    end else if (byte_en) begin
      b_r <= b_r + BCW'(1);
      case (b_r)
        2'd0:    low_r[7:0]   <= byte_data;
        2'd1:    low_r[15:8]  <= byte_data;
        2'd2:    low_r[23:16] <= byte_data;
        default: low_r        <= low_r;
      endcase
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Program loader: streams bytes into imem as 32-bit words and holds the CPU
// stalled until the image is in place. Define IMEM_LOAD_CSUM_EN for the checksum stage.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW:0]       len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  localparam int LW = AW + 1;

  state_t            state_r, state_nxt;
  logic [LW-1:0]     len_r, len_nxt;
  logic [LW-1:0]     w_r, w_nxt;
  logic              byte_ready_r, byte_ready_nxt;
  logic              mem_we_r, mem_we_nxt;
  logic [AW-1:0]     mem_waddr_r, mem_waddr_nxt;
  logic [WORD_W-1:0] mem_wdata_r, mem_wdata_nxt;
  logic              cpu_stall_r, cpu_stall_nxt;
  logic              done_r, done_nxt;
  logic              err_r, err_nxt;
  logic              hs_s, len_ok_s, pk_clear_s, word_valid_s;
  logic [WORD_W-1:0] word_s;
`ifdef IMEM_LOAD_CSUM_EN
  logic [WORD_W-1:0] csum_r, csum_nxt;
`endif

  assign hs_s     = byte_valid && byte_ready_r;
  assign len_ok_s = (len != {LW{1'b0}}) && (len <= LW'(DEPTH));

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear_s),
    .byte_en    (hs_s),
    .byte_data  (byte_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state logic; every output is computed one cycle ahead and registered
  always_comb begin
    state_nxt     = state_r;
    len_nxt       = len_r;
    w_nxt         = w_r;
    err_nxt       = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_waddr_nxt = mem_waddr_r;
    mem_wdata_nxt = mem_wdata_r;
    pk_clear_s    = 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
    csum_nxt      = csum_r;
`endif
    case (state_r)
      IDLE, RUN: begin
        if (start && len_ok_s) begin
          state_nxt  = LOAD;
          len_nxt    = len;
          w_nxt      = {LW{1'b0}};
          pk_clear_s = 1'b1;
`ifdef IMEM_LOAD_CSUM_EN
          csum_nxt   = {WORD_W{1'b0}};
`endif
        end else if (start) begin
          err_nxt = 1'b1;
        end else begin
          state_nxt = state_r;
        end
      end
      LOAD: begin
        if (word_valid_s) begin
          mem_we_nxt    = 1'b1;
          mem_waddr_nxt = w_r[AW-1:0];
          mem_wdata_nxt = word_s;
          w_nxt         = w_r + LW'(1);
`ifdef IMEM_LOAD_CSUM_EN
          csum_nxt      = csum_add(csum_r, word_s);
`endif
        end else if (mem_we_r && (w_r == len_r)) begin
          // Leave only once the final word's write cycle has completed
`ifdef IMEM_LOAD_CSUM_EN
          state_nxt = CHK;
`else
          state_nxt = RUN;
`endif
        end else begin
          state_nxt = LOAD;
        end
      end
      CHK: begin
`ifdef IMEM_LOAD_CSUM_EN
        if (word_valid_s && (word_s == csum_r)) begin
          state_nxt = RUN;
        end else if (word_valid_s) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = CHK;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    byte_ready_nxt = ((state_nxt == LOAD) || (state_nxt == CHK)) && !mem_we_nxt;
    done_nxt       = (state_nxt == RUN);
    cpu_stall_nxt  = (state_nxt != RUN);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      len_r        <= {LW{1'b0}};
      w_r          <= {LW{1'b0}};
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_waddr_r  <= {AW{1'b0}};
      mem_wdata_r  <= {WORD_W{1'b0}};
      cpu_stall_r  <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
      csum_r       <= {WORD_W{1'b0}};
`endif
    end else begin
      state_r      <= state_nxt;
      len_r        <= len_nxt;
      w_r          <= w_nxt;
      byte_ready_r <= byte_ready_nxt;
      mem_we_r     <= mem_we_nxt;
      mem_waddr_r  <= mem_waddr_nxt;
      mem_wdata_r  <= mem_wdata_nxt;
      cpu_stall_r  <= cpu_stall_nxt;
      done_r       <= done_nxt;
      err_r        <= err_nxt;
`ifdef IMEM_LOAD_CSUM_EN
      csum_r       <= csum_nxt;
`endif
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_stall  = cpu_stall_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed, scoreboard-based bench for imem_load_ctrl (checksum steps
// are included when IMEM_LOAD_CSUM_EN is defined).
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [6:0]  len;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_stall, done, err;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  imem_load_ctrl #(.DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("waddr", {26'd0, mem_waddr}, {26'd0, e.addr});
        check("wdata", mem_wdata, e.data);
      end
    end
  end

  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   cyc;
    logic hs;
    byte_valid = 1'b1;
    byte_data  = b;
    cyc = 0;
    do begin
      @(negedge clk);
      hs = byte_ready;
      @(posedge clk); #1;
      cyc++;
    end while (!hs && cyc < 50);
    if (!hs) check("byte_ready_timeout", 32'(hs), 32'd1);
    byte_valid = 1'b0;
  endtask

  // Sends img_q as bytes, optionally with random 1..max_gap idle cycles
  task automatic load_image(input int max_gap);
    logic [31:0] w;
    for (int i = 0; i < img_q.size(); i++) begin
      w = img_q[i];
      exp_q.push_back('{addr: 6'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        if (max_gap > 0 && b > 0) repeat ($urandom_range(1, max_gap)) @(posedge clk);
        if (max_gap > 0 && b > 0) #1;
        send_byte(w[8*b +: 8]);
      end
    end
  endtask

  task automatic finish_load(input string tag, input logic good_csum);
    logic [31:0] sum;
    sum = 32'd0;
    foreach (img_q[i]) sum = sum + img_q[i];
`ifdef IMEM_LOAD_CSUM_EN
    if (!good_csum) sum = 32'd0;
    for (int b = 0; b < 4; b++) send_byte(sum[8*b +: 8]);
    check({tag, "_done"}, {31'd0, done}, {31'd0, good_csum});
    check({tag, "_stall"}, {31'd0, cpu_stall}, {31'd0, !good_csum});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !good_csum});
`else
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, done}, {31'd0, good_csum});
    check({tag, "_stall"}, {31'd0, cpu_stall}, {31'd0, !good_csum});
`endif
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 7'd0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) @(posedge clk); #1;
    check("rst_stall", {31'd0, cpu_stall}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Illegal lengths in IDLE
    do_start(7'd0);
    check("len0_err", {31'd0, err}, 32'd1);
    check("len0_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1;
    check("len0_err_pulse", {31'd0, err}, 32'd0);
    do_start(7'd65);
    check("len65_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    check("len65_err_pulse", {31'd0, err}, 32'd0);
    check("len65_stall", {31'd0, cpu_stall}, 32'd1);
    check("len65_ready", {31'd0, byte_ready}, 32'd0);

    // Basic two-word load
    img_q.delete();
    img_q.push_back(32'h0010_0813);
    img_q.push_back(32'hFF40_0893);
    do_start(7'd2);
    check("basic_ready", {31'd0, byte_ready}, 32'd1);
    load_image(0);
    finish_load("basic", 1'b1);
    check("hold_waddr", {26'd0, mem_waddr}, 32'd1);
    check("hold_wdata", mem_wdata, 32'hFF40_0893);

    // Illegal start while running
    do_start(7'd65);
    check("run_bad_err", {31'd0, err}, 32'd1);
    check("run_bad_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("run_bad_err_pulse", {31'd0, err}, 32'd0);

    // Reload from RUN with random byte_valid gaps
    img_q.delete();
    img_q.push_back(32'h1122_3344);
    img_q.push_back(32'hA5A5_0F0F);
    img_q.push_back(32'h0000_00FF);
    do_start(7'd3);
    check("reload_stall", {31'd0, cpu_stall}, 32'd1);
    check("reload_done", {31'd0, done}, 32'd0);
    load_image(5);
    finish_load("bp", 1'b1);

    // Reset after six bytes of a four-word load
    img_q.delete();
    img_q.push_back(32'h7654_3210);
    do_start(7'd4);
    exp_q.push_back('{addr: 6'd0, data: 32'h7654_3210});
    for (int b = 0; b < 4; b++) send_byte(img_q[0][8*b +: 8]);
    send_byte(8'hEE);
    send_byte(8'hDD);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {31'd0, cpu_stall}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_first_word", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    img_q.delete();
    img_q.push_back(32'hCAFE_F00D);
    do_start(7'd1);
    load_image(0);
    finish_load("after_rst", 1'b1);

`ifdef IMEM_LOAD_CSUM_EN
    // Wrong checksum drops back to IDLE
    img_q.delete();
    img_q.push_back(32'h0010_0813);
    img_q.push_back(32'hFF40_0893);
    do_start(7'd2);
    load_image(0);
    finish_load("bad_csum", 1'b0);
    @(posedge clk); #1;
    check("bad_csum_err_pulse", {31'd0, err}, 32'd0);
    check("bad_csum_idle", {31'd0, byte_ready}, 32'd0);
`endif

    repeat (3) @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
